riscv_pipe_hazard_ctrl: RTL and testbench

- Parametrised PC-generation and hazard-control block for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
- Owns the PC register and the per-stage valid bits.
- Detects load-use and RAW hazards, generates stall, bubble and flush controls, and drives EX-stage operand forwarding selects.
- The datapath instantiates it once and consumes its controls at each pipeline register.

---
 rtl/riscv_pipe_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_riscv_pipe_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_pipe_hazard_ctrl.sv
// PC generation and hazard control for the 5-stage RV32 pipeline.
// Owns the PC register and the per-stage valid bits. It detects load-use and
// RAW hazards, drives the stall/bubble/flush controls and the EX forwarding selects.
// Optional feature macro: RISCV_PIPE_FWD_EN
//   defined   : EX operand forwarding; only load-use hazards stall, for LOAD_USE_STALLS cycles.
//   undefined : no forwarding; any EX or MEM writer feeding an ID source stalls.
module riscv_pipe_hazard_ctrl #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] PC_INITIAL      = 32'h00400000,
  parameter int              REG_ADDR_W      = 5,
  parameter int              LOAD_USE_STALLS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  ex_branch_taken,
  input  logic [XLEN-1:0]       ex_branch_target,
  output logic [XLEN-1:0]       PC,
  output logic [3:0]            stage_valid,
  output logic                  stall,
  output logic                  bubble,
  output logic                  flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [3:0]      valid_q, valid_d;
  logic            id_use1, id_use2;
  logic            ex_wr, mem_wr;
  logic            stall_c, bubble_c, flush_c;

  // Every stage's inputs only count while that stage holds a live instruction;
  // x0 is never a real destination.
  assign id_use1 = valid_q[0] & id_uses_rs1;
  assign id_use2 = valid_q[0] & id_uses_rs2;
  assign ex_wr   = valid_q[1] & ex_reg_write & (ex_rd != '0);
  assign mem_wr  = valid_q[2] & mem_reg_write & (mem_rd != '0);
  assign flush_c = valid_q[1] & ex_branch_taken;

`ifdef RISCV_PIPE_FWD_EN
  localparam int CNT_W = 2;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic                  ex_use1_q, ex_use1_d, ex_use2_q, ex_use2_d;
  logic                  wb_wr, load_use;

  // MEM has the younger result, so it beats WB for the same register.
  function automatic logic [1:0] fwd_sel(input logic                  src_used,
                                         input logic [REG_ADDR_W-1:0] src,
                                         input logic                  m_wr,
                                         input logic [REG_ADDR_W-1:0] m_rd,
                                         input logic                  w_wr,
                                         input logic [REG_ADDR_W-1:0] w_rd);
    fwd_sel = 2'b00;
    if (src_used && w_wr && (w_rd == src)) fwd_sel = 2'b01;
    if (src_used && m_wr && (m_rd == src)) fwd_sel = 2'b10;
  endfunction

  assign wb_wr    = valid_q[3] & wb_reg_write & (wb_rd != '0);
  assign load_use = ex_wr & ex_mem_read &
                    ((id_use1 & (id_rs1 == ex_rd)) | (id_use2 & (id_rs2 == ex_rd)));

  // Load-use stall sequencing; a flush kills the stall and the pending count.
  always_comb begin
    stall_c  = ~flush_c & (load_use | (cnt_q != '0));
    bubble_c = stall_c;
    cnt_d    = '0;
    if (!flush_c) begin
      if (cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
      else if (load_use) cnt_d = CNT_W'(LOAD_USE_STALLS - 1);
    end
    ex_rs1_d  = id_rs1;
    ex_rs2_d  = id_rs2;
    ex_use1_d = id_use1 & ~(flush_c | bubble_c);
    ex_use2_d = id_use2 & ~(flush_c | bubble_c);
  end

  // Stall counter and the EX-stage source-use flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      ex_use1_q <= 1'b0;
      ex_use2_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ex_use1_q <= ex_use1_d;
      ex_use2_q <= ex_use2_d;
    end
  end

  // EX-stage source indices; meaningful only when the matching use flag is set.
  always_ff @(posedge clk) begin
    ex_rs1_q <= ex_rs1_d;
    ex_rs2_q <= ex_rs2_d;
  end

  assign fwd_a = fwd_sel(ex_use1_q, ex_rs1_q, mem_wr, mem_rd, wb_wr, wb_rd);
  assign fwd_b = fwd_sel(ex_use2_q, ex_rs2_q, mem_wr, mem_rd, wb_wr, wb_rd);
`else
  logic ex_hit, mem_hit;
  logic unused_inputs;

  // Without forwarding, wait until the producer reaches WB; the register file
  // writes before it reads, so WB writers never need a stall.
  assign ex_hit   = ex_wr & ((id_use1 & (id_rs1 == ex_rd)) | (id_use2 & (id_rs2 == ex_rd)));
  assign mem_hit  = mem_wr & ((id_use1 & (id_rs1 == mem_rd)) | (id_use2 & (id_rs2 == mem_rd)));
  assign stall_c  = ~flush_c & (ex_hit | mem_hit);
  assign bubble_c = stall_c;
  assign fwd_a    = 2'b00;
  assign fwd_b    = 2'b00;

  assign unused_inputs = ^{wb_rd, wb_reg_write, ex_mem_read, LOAD_USE_STALLS[0]};
`endif

  // Next PC and valid-bit advance: flush redirects, stall holds, else sequential fetch.
  always_comb begin
    pc_d = pc_q + XLEN'(4);
    if (flush_c)      pc_d = ex_branch_target;
    else if (stall_c) pc_d = pc_q;
    valid_d[0]   = flush_c ? 1'b0 : (stall_c ? valid_q[0] : 1'b1);
    valid_d[1]   = (flush_c | bubble_c) ? 1'b0 : valid_q[0];
    valid_d[3:2] = valid_q[2:1];
  end

  // PC and stage-valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= PC_INITIAL;
      valid_q <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign PC          = pc_q;
  assign stage_valid = valid_q;
  assign stall       = stall_c;
  assign bubble      = bubble_c;
  assign flush       = flush_c;

endmodule

// File: tb/tb_riscv_pipe_hazard_ctrl.sv
// Directed bench for riscv_pipe_hazard_ctrl with a queue of expected outputs.
module tb_riscv_pipe_hazard_ctrl;
  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int LUS  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [RAW-1:0]  id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic            id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_read;
  logic            mem_reg_write, wb_reg_write, ex_branch_taken;
  logic [XLEN-1:0] ex_branch_target;
  logic [XLEN-1:0] PC;
  logic [3:0]      stage_valid;
  logic            stall, bubble, flush;
  logic [1:0]      fwd_a, fwd_b;

  riscv_pipe_hazard_ctrl #(
    .XLEN(XLEN), .PC_INITIAL(32'h00400000), .REG_ADDR_W(RAW), .LOAD_USE_STALLS(LUS)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .PC(PC), .stage_valid(stage_valid), .stall(stall), .bubble(bubble), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [3:0]  sv;
    logic        st;
    logic        bb;
    logic        fl;
    logic [1:0]  fa;
    logic [1:0]  fb;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
    ex_branch_taken = 1'b0; ex_branch_target = '0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc, input logic [3:0] sv,
                            input logic st, input logic bb, input logic fl,
                            input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e.tag = tag; e.pc = pc; e.sv = sv; e.st = st; e.bb = bb; e.fl = fl; e.fa = fa; e.fb = fb;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cmp_all();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, "/pc"},     PC,                   e.pc);
    cmp({e.tag, "/valid"},  {28'd0, stage_valid}, {28'd0, e.sv});
    cmp({e.tag, "/stall"},  {31'd0, stall},       {31'd0, e.st});
    cmp({e.tag, "/bubble"}, {31'd0, bubble},      {31'd0, e.bb});
    cmp({e.tag, "/flush"},  {31'd0, flush},       {31'd0, e.fl});
    cmp({e.tag, "/fwd_a"},  {30'd0, fwd_a},       {30'd0, e.fa});
    cmp({e.tag, "/fwd_b"},  {30'd0, fwd_b},       {30'd0, e.fb});
  endtask

  // Compare just before the next rising edge, then advance one cycle.
  task automatic step();
    @(negedge clk);
    cmp_all();
    @(posedge clk);
    #1;
  endtask

  // Observe the stall driven for this cycle, then reset asynchronously mid-cycle.
  task automatic reset_mid_stall();
    @(negedge clk);
    cmp_all();
    #2 rst = 1'b1;
    #1;
    expect_out("rst_async", 32'h00400000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    cmp_all();
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    expect_out("post_rst0", 32'h00400000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step();
    expect_out("post_rst1", 32'h00400004, 4'b0001, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    // Hazard-looking inputs while every stage is invalid must raise nothing.
    id_rs1 = 5'd5; id_uses_rs1 = 1'b1; ex_rd = 5'd5; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    mem_rd = 5'd5; mem_reg_write = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 32'h12345678;
    expect_out("reset", 32'h00400000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step();
    rst = 1'b0;
    idle();

    for (int i = 0; i < 4; i++) begin
      expect_out("fill", 32'h00400000 + 32'(4 * i), 4'((1 << i) - 1),
                 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step();
    end

`ifdef RISCV_PIPE_FWD_EN
    id_rs1 = 5'd3; id_uses_rs1 = 1'b1; id_rs2 = 5'd4; id_uses_rs2 = 1'b1;
    expect_out("fwd_setup", 32'h00400010, 4'b1111, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step();
    idle();
    mem_rd = 5'd3; mem_reg_write = 1'b1; wb_rd = 5'd3; wb_reg_write = 1'b1;
    id_rs1 = 5'd4; id_uses_rs1 = 1'b1; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    expect_out("fwd_mem_prio", 32'h00400014, 4'b1111, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
    step();
    idle();
    mem_rd = 5'd0; mem_reg_write = 1'b1; wb_rd = 5'd4; wb_reg_write = 1'b1;
    expect_out("fwd_wb_x0", 32'h00400018, 4'b1111, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
    step();
    idle();
    ex_rd = 5'd5; ex_reg_write = 1'b1; ex_mem_read = 1'b1; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    expect_out("lu_detect", 32'h0040001C, 4'b1111, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    step();
    idle();
    expect_out("lu_stall2", 32'h0040001C, 4'b1101, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    step();
    expect_out("lu_stall3", 32'h0040001C, 4'b1001, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    step();
    expect_out("lu_release", 32'h0040001C, 4'b0001, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step();
    ex_rd = 5'd6; ex_reg_write = 1'b1; ex_mem_read = 1'b1; id_rs1 = 5'd6; id_uses_rs1 = 1'b1;
    ex_branch_taken = 1'b1; ex_branch_target = 32'h00400100;
    expect_out("flush_vs_lu", 32'h00400020, 4'b0011, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    step();
    idle();
    expect_out("after_flush", 32'h00400100, 4'b0100, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step();
    expect_out("refill", 32'h00400104, 4'b1001, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step();
    ex_branch_taken = 1'b1; ex_branch_target = 32'hFFFFFFFC;
    expect_out("br_top", 32'h00400108, 4'b0011, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    step();
    idle();
    expect_out("pc_top", 32'hFFFFFFFC, 4'b0100, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step();
    expect_out("pc_wrap", 32'h00000000, 4'b1001, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step();
    ex_rd = 5'd5; ex_reg_write = 1'b1; ex_mem_read = 1'b1; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    expect_out("lu_again", 32'h00000004, 4'b0011, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    step();
    idle();
    expect_out("lu_cnt", 32'h00000004, 4'b0101, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    reset_mid_stall();
`else
    ex_rd = 5'd7; ex_reg_write = 1'b1; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    expect_out("raw_ex", 32'h00400010, 4'b1111, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    step();
    idle();
    mem_rd = 5'd7; mem_reg_write = 1'b1; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    expect_out("raw_mem", 32'h00400010, 4'b1101, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    step();
    idle();
    wb_rd = 5'd7; wb_reg_write = 1'b1; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    expect_out("raw_wb_free", 32'h00400010, 4'b1001, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step();
    idle();
    ex_rd = 5'd9; ex_reg_write = 1'b1; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
    ex_branch_taken = 1'b1; ex_branch_target = 32'h00400100;
    expect_out("flush_vs_raw", 32'h00400014, 4'b0011, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    step();
    idle();
    ex_branch_taken = 1'b1; ex_branch_target = 32'h00000040;
    expect_out("br_unqual", 32'h00400100, 4'b0100, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step();
    idle();
    expect_out("refill", 32'h00400104, 4'b1001, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step();
    ex_rd = 5'd0; ex_reg_write = 1'b1; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    expect_out("x0_no_match", 32'h00400108, 4'b0011, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step();
    idle();
    mem_rd = 5'd5; mem_reg_write = 1'b1; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    expect_out("raw_mem_rs2", 32'h0040010C, 4'b0111, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    step();
    idle();
    expect_out("resume", 32'h0040010C, 4'b1101, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step();
    ex_branch_taken = 1'b1; ex_branch_target = 32'hFFFFFFFC;
    expect_out("br_top", 32'h00400110, 4'b1011, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    step();
    idle();
    expect_out("pc_top", 32'hFFFFFFFC, 4'b0100, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step();
    expect_out("pc_wrap", 32'h00000000, 4'b1001, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step();
    ex_rd = 5'd5; ex_reg_write = 1'b1; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    expect_out("raw_again", 32'h00000004, 4'b0011, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    step();
    idle();
    mem_rd = 5'd5; mem_reg_write = 1'b1; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    expect_out("raw_mem_again", 32'h00000004, 4'b0101, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    reset_mid_stall();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
